fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter EXC_VECTOR, default 32'h8000_0180, fetch address on exception or misaligned redirect.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  32  word address of the outstanding request.
REQ-007 imem_ack  input  1  memory returns imem_rdata this cycle; valid only while imem_req=1.
REQ-008 imem_rdata  input  32  instruction word.
REQ-009 instr_valid  output  1  instr/instr_pc hold an instruction for decode.
REQ-010 instr  output  32  fetched instruction.
REQ-011 instr_pc  output  32  address of instr.
REQ-012 instr_ready  input  1  decode accepts instr when instr_valid=1.
REQ-013 redirect_valid  input  1  one-cycle branch/jump redirect.
REQ-014 redirect_target  input  32  redirect address.
REQ-015 exc_valid  input  1  one-cycle exception redirect to EXC_VECTOR.
REQ-016 addr_fault  output  1  one-cycle pulse when the accepted redirect_target is misaligned.

Function
REQ-017 The block SHALL implement FSM states BOOT, REQ, HOLD; pc register (32 bit) holds the next fetch address.
REQ-018 BOOT SHALL last exactly one cycle after reset release, then go to REQ; imem_req=0 in BOOT.
REQ-019 In REQ, imem_req=1 and imem_addr=pc; both SHALL stay stable until imem_ack=1 or a redirect.
REQ-020 On imem_ack with no redirect: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0).
REQ-021 Ack is accepted only when the output buffer is empty or drained this cycle (instr_valid=0 or instr_ready=1); otherwise imem_req SHALL be 0 and FSM is in HOLD.
REQ-022 HOLD SHALL return to REQ in the cycle after instr_ready=1; an instr_ready/ack coincidence in REQ SHALL load the new word with no bubble (one instruction per cycle sustained with zero-latency memory).
REQ-023 instr_valid SHALL clear on instr_ready=1 unless a new word is loaded in the same cycle.
REQ-024 Redirect priority: exc_valid > redirect_valid > sequential.
REQ-025 On exc_valid: pc<=EXC_VECTOR, instr_valid<=0, any same-cycle imem_ack data discarded, FSM<=REQ next cycle.
REQ-026 On redirect_valid: if redirect_target[1:0]==0, pc<=redirect_target; else pc<=EXC_VECTOR and addr_fault=1 for one cycle; instr_valid<=0, same-cycle ack discarded, FSM<=REQ.
REQ-027 A redirect during REQ without ack SHALL drop the request for one cycle (imem_req=0), then reissue at the new pc; memory must not hold a stale ack across a deasserted request.
REQ-028 imem_addr[1:0] and instr_pc[1:0] SHALL always be 2'b00.

Reset
REQ-029 rst_n=0 SHALL immediately force: FSM=BOOT, pc=RESET_VECTOR, imem_req=0, imem_addr=RESET_VECTOR, instr_valid=0, instr=0, instr_pc=0, addr_fault=0.
REQ-030 Reset asserted mid-request SHALL abandon the request; no instruction from it is delivered.

Structure
REQ-031 FSM state encoding, the PC increment constant (4) and default vectors SHALL live in the shared package mips_pkg.
REQ-032 The pc register and incrementer SHALL be one sub-module, pc_unit (load/increment/hold controls); FSM and output buffer stay in fetch_sequencer.

Verification
REQ-033 Reset release, ack tied 1, ready tied 1 -> BOOT one cycle; instr_pc sequence 0x0,0x4,0x8 on consecutive cycles.
REQ-034 ready=0 after first word -> imem_req=0 (HOLD), instr/instr_pc stable; ready=1 -> next fetch at 0x4 the following cycle.
REQ-035 redirect_valid with target 0x0000_0100 coincident with ack of 0x8 -> word for 0x8 discarded, next request at 0x100.
REQ-036 redirect_target 0x0000_0102 -> addr_fault pulse of one cycle, next request at 0x8000_0180.
REQ-037 exc_valid and redirect_valid(0x200) in the same cycle -> next request at 0x8000_0180, addr_fault=0.
REQ-038 pc forced to 0xFFFF_FFFC via redirect, ack -> instr_pc=0xFFFF_FFFC, next imem_addr=0x0; rst_n low mid-REQ -> outputs at reset values within the same cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch front end: fetch FSM state
// encoding, PC step and default reset/exception vectors.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;

  // Instructions are 32-bit words; anything else is an illegal fetch target.
  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of the fetch front end's memory, decode and redirect signals.
// master: the fetch sequencer; slave: memory/decode/branch environment.
interface fetch_sequencer_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        exc_valid;
  logic        addr_fault;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, addr_fault,
    input  imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_target, exc_valid
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, addr_fault,
    output imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_target, exc_valid
  );

endinterface

// File: rtl/pc_unit.sv
// Program counter: holds the next fetch address; load wins over increment.
module pc_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_addr,
  input  logic        inc,
  output logic [31:0] pc
);

  // PC register: redirect load, sequential step (wraps modulo 2^32) or hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_VECTOR;
    end else if (load) begin
      pc <= load_addr;
    end else if (inc) begin
      pc <= pc + PC_INC;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues word reads from pc, buffers one
// instruction for decode, and handles branch/exception redirects.
module fetch_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_sequencer_if.master  bus
);

  fetch_state_e state, state_nx;

  logic [31:0] pc;
  logic        pc_load;
  logic [31:0] pc_load_addr;
  logic        pc_inc;

  logic redir;
  logic buf_ok;
  logic ack_take;
  logic bad_target;

  // Any redirect flushes the buffer and kills the in-flight request.
  assign redir      = bus.exc_valid | bus.redirect_valid;
  // The buffer can take a word if it is empty or being drained this cycle.
  assign buf_ok     = ~bus.instr_valid | bus.instr_ready;
  assign ack_take   = bus.imem_req & bus.imem_ack;
  assign bad_target = ~is_word_aligned(bus.redirect_target);
  // pc only ever loads aligned values, so the address is always word aligned.
  assign bus.imem_addr = pc;

  pc_unit #(
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (pc_load),
    .load_addr (pc_load_addr),
    .inc       (pc_inc),
    .pc        (pc)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BOOT;
    end else begin
      state <= state_nx;
    end
  end

  // Next state, request gating and pc control.
  always_comb begin
    state_nx     = state;
    bus.imem_req = 1'b0;
    pc_load      = redir;
    pc_load_addr = (bus.exc_valid || bad_target) ? EXC_VECTOR : bus.redirect_target;
    pc_inc       = 1'b0;
    case (state)
      ST_BOOT: begin
        state_nx = ST_REQ;
      end
      ST_REQ: begin
        // A redirect withdraws the request this cycle; reissue from the new pc.
        bus.imem_req = buf_ok & ~redir;
        if (redir) begin
          state_nx = ST_REQ;
        end else if (!buf_ok) begin
          state_nx = ST_HOLD;
        end
        pc_inc = ack_take;
      end
      ST_HOLD: begin
        if (redir || bus.instr_ready) begin
          state_nx = ST_REQ;
        end
      end
      default: begin
        state_nx = ST_BOOT;
      end
    endcase
  end

  // Single-entry output buffer towards decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.instr_valid <= 1'b0;
      bus.instr       <= '0;
      bus.instr_pc    <= '0;
    end else if (redir) begin
      bus.instr_valid <= 1'b0;
    end else if (ack_take) begin
      bus.instr_valid <= 1'b1;
      bus.instr       <= bus.imem_rdata;
      bus.instr_pc    <= pc;
    end else if (bus.instr_ready) begin
      bus.instr_valid <= 1'b0;
    end
  end

  // Misaligned-target pulse, suppressed when an exception takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.addr_fault <= 1'b0;
    end else begin
      bus.addr_fault <= bus.redirect_valid & ~bus.exc_valid & bad_target;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios with literal expectations,
// then randomized traffic checked cycle by cycle against a queue-based model.
module tb_fetch_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] EV = 32'h8000_0180;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fetch_sequencer_if bus_if();

  fetch_sequencer #(
    .RESET_VECTOR (RV),
    .EXC_VECTOR   (EV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.master)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  // Model: booting/holding flags, next fetch address, delivered-word queue.
  ent_t        m_q[$];
  bit          m_boot;
  bit          m_hold;
  logic [31:0] m_pc;
  bit          m_fault;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_boot  = 1'b1;
    m_hold  = 1'b0;
    m_pc    = RV;
    m_fault = 1'b0;
    m_q.delete();
  endtask

  task automatic drive_idle();
    bus_if.imem_ack        = 1'b0;
    bus_if.imem_rdata      = '0;
    bus_if.instr_ready     = 1'b0;
    bus_if.redirect_valid  = 1'b0;
    bus_if.redirect_target = '0;
    bus_if.exc_valid       = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare all outputs with the model, then
  // advance the model to what the coming rising edge must produce.
  task automatic step(input bit ack, input bit rdy, input bit rv,
                      input logic [31:0] tgt, input bit exc);
    logic [31:0] word;
    bit redir, e_req, acc;
    @(negedge clk);
    word = $urandom;
    bus_if.imem_ack        = ack;
    bus_if.imem_rdata      = word;
    bus_if.instr_ready     = rdy;
    bus_if.redirect_valid  = rv;
    bus_if.redirect_target = tgt;
    bus_if.exc_valid       = exc;
    #1;
    redir = rv || exc;
    e_req = !m_boot && !m_hold && (m_q.size() == 0 || rdy) && !redir;
    chk("imem_req", {31'd0, bus_if.imem_req}, {31'd0, e_req});
    chk("imem_addr", bus_if.imem_addr, m_pc);
    chk("instr_valid", {31'd0, bus_if.instr_valid}, {31'd0, m_q.size() != 0});
    if (m_q.size() != 0) begin
      chk("instr", bus_if.instr, m_q[0].word);
      chk("instr_pc", bus_if.instr_pc, m_q[0].pc);
    end
    chk("addr_fault", {31'd0, bus_if.addr_fault}, {31'd0, m_fault});

    acc     = e_req && ack;
    m_fault = !exc && rv && (tgt[1:0] != 2'b00);
    if (redir) begin
      m_pc   = exc ? EV : ((tgt[1:0] != 2'b00) ? EV : tgt);
      m_q.delete();
      m_boot = 1'b0;
      m_hold = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_hold) begin
      if (rdy) begin
        m_q.delete();
        m_hold = 1'b0;
      end
    end else begin
      if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
      if (acc) begin
        m_q.push_back('{pc: m_pc, word: word});
        m_pc = m_pc + 32'd4;
      end
      if (!e_req) m_hold = 1'b1;
    end
  endtask

  // Assert reset mid-cycle, check outputs fall to reset values at once,
  // hold it two edges, release between edges.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    drive_idle();
    #1;
    chk("rst_imem_req", {31'd0, bus_if.imem_req}, 32'd0);
    chk("rst_imem_addr", bus_if.imem_addr, RV);
    chk("rst_instr_valid", {31'd0, bus_if.instr_valid}, 32'd0);
    chk("rst_instr", bus_if.instr, 32'd0);
    chk("rst_instr_pc", bus_if.instr_pc, 32'd0);
    chk("rst_addr_fault", {31'd0, bus_if.addr_fault}, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    drive_idle();
    model_reset();
    do_reset();

    // Streaming with ack and ready tied high.
    step(1, 1, 0, 0, 0);
    chk("boot_req", {31'd0, bus_if.imem_req}, 32'd0);
    step(1, 1, 0, 0, 0);
    chk("first_req", {31'd0, bus_if.imem_req}, 32'd1);
    chk("first_addr", bus_if.imem_addr, 32'h0);
    step(1, 1, 0, 0, 0);
    chk("seq_pc0", bus_if.instr_pc, 32'h0);
    step(1, 1, 0, 0, 0);
    chk("seq_pc4", bus_if.instr_pc, 32'h4);
    step(1, 1, 0, 0, 0);
    chk("seq_pc8", bus_if.instr_pc, 32'h8);

    // Back-pressure: decode stalls after the first word.
    do_reset();
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("stall_req", {31'd0, bus_if.imem_req}, 32'd0);
    chk("stall_pc", bus_if.instr_pc, 32'h0);
    step(0, 0, 0, 0, 0);
    chk("hold_req", {31'd0, bus_if.imem_req}, 32'd0);
    chk("hold_pc", bus_if.instr_pc, 32'h0);
    step(0, 1, 0, 0, 0);
    chk("hold_drain_req", {31'd0, bus_if.imem_req}, 32'd0);
    step(1, 1, 0, 0, 0);
    chk("resume_req", {31'd0, bus_if.imem_req}, 32'd1);
    chk("resume_addr", bus_if.imem_addr, 32'h4);

    // Redirect coincident with the ack for 0x8.
    do_reset();
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 32'h0000_0100, 0);
    chk("redir_cycle_addr", bus_if.imem_addr, 32'h8);
    step(0, 1, 0, 0, 0);
    chk("redir_new_addr", bus_if.imem_addr, 32'h0000_0100);
    chk("redir_new_req", {31'd0, bus_if.imem_req}, 32'd1);
    chk("redir_discard", {31'd0, bus_if.instr_valid}, 32'd0);

    // Misaligned redirect target.
    step(0, 1, 1, 32'h0000_0102, 0);
    step(0, 1, 0, 0, 0);
    chk("fault_pulse", {31'd0, bus_if.addr_fault}, 32'd1);
    chk("fault_addr", bus_if.imem_addr, EV);
    step(0, 1, 0, 0, 0);
    chk("fault_end", {31'd0, bus_if.addr_fault}, 32'd0);

    // Exception beats a simultaneous redirect.
    step(0, 1, 1, 32'h0000_0200, 1);
    step(0, 1, 0, 0, 0);
    chk("exc_addr", bus_if.imem_addr, EV);
    chk("exc_nofault", {31'd0, bus_if.addr_fault}, 32'd0);

    // PC wrap at the top of the address space, then reset mid-request.
    step(0, 1, 1, 32'hFFFF_FFFC, 0);
    step(1, 1, 0, 0, 0);
    chk("wrap_addr", bus_if.imem_addr, 32'hFFFF_FFFC);
    step(0, 1, 0, 0, 0);
    chk("wrap_instr_pc", bus_if.instr_pc, 32'hFFFF_FFFC);
    chk("wrap_next_addr", bus_if.imem_addr, 32'h0);
    do_reset();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        tgt = $urandom;
        if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
        step($urandom_range(0, 3) != 0,
             $urandom_range(0, 9) < 7,
             $urandom_range(0, 19) == 0,
             tgt,
             $urandom_range(0, 39) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
